// File: rtl/mips_regfile_pkg.sv
// Shared sizes, index constants and word/index types for the MIPS register file.
// Build option: REGFILE_WRITE_BYPASS_EN enables same-cycle write forwarding on the read ports.
package mips_regfile_pkg;
    localparam int REG_COUNT  = 32;
    localparam int REG_IDX_W  = 5;
    localparam int REG_DATA_W = 32;

    typedef logic [REG_IDX_W-1:0]  reg_idx_t;
    typedef logic [REG_DATA_W-1:0] reg_word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_V0   = 5'd2;
    localparam reg_idx_t REG_RA   = 5'd31;
endpackage

// File: rtl/mips_register_file_if.sv
// Decode/writeback-side bus of the register file: one write port, two read ports, v0 tap.
// master drives indices and write data; slave (the register file) returns read data.
interface mips_register_file_if import mips_regfile_pkg::*; ();
    logic      write_enable;
    reg_idx_t  register_a_index;
    reg_idx_t  register_b_index;
    reg_idx_t  write_register;
    reg_word_t write_data;
    reg_word_t register_a_data;
    reg_word_t register_b_data;
    reg_word_t v0;

    modport master (
        output write_enable, register_a_index, register_b_index, write_register, write_data,
        input  register_a_data, register_b_data, v0
    );

    modport slave (
        input  write_enable, register_a_index, register_b_index, write_register, write_data,
        output register_a_data, register_b_data, v0
    );
endinterface

// File: rtl/mips_register_file_read_port.sv
// One combinational read port: index mux, $zero forcing, optional write bypass
// (REGFILE_WRITE_BYPASS_EN). Zero latency, no backpressure.
module mips_regfile_read_port
    import mips_regfile_pkg::*;
(
    input  reg_idx_t  i_idx,
`ifdef REGFILE_WRITE_BYPASS_EN
    input  logic      i_byp_vld,
    input  reg_idx_t  i_byp_idx,
    input  reg_word_t i_byp_dat,
`endif
    input  reg_word_t i_regs [REG_COUNT],
    output reg_word_t o_dat
);
    always_comb begin
        o_dat = (i_idx == REG_ZERO) ? '0 : i_regs[i_idx];
`ifdef REGFILE_WRITE_BYPASS_EN
        // i_byp_vld already excludes $zero and reset, so a plain index match suffices
        if (i_byp_vld && (i_byp_idx == i_idx)) begin
            o_dat = i_byp_dat;
        end
`endif
    end
endmodule

// File: rtl/mips_register_file.sv
// 32x32 MIPS register file: async reads (A/B), one sync write, v0 export; $zero has no storage.
// Reads zero-latency, writes one edge; optional REGFILE_WRITE_BYPASS_EN forwards write data.
module mips_register_file
    import mips_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_W,
    parameter int ADDR_WIDTH = REG_IDX_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    mips_register_file_if.slave  rf
);
    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [1:NREGS-1];
    reg_word_t             w_regs [REG_COUNT];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 1; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (rf.write_enable && (rf.write_register != REG_ZERO)) begin
            r_regs[rf.write_register] <= rf.write_data;
        end
    end

    always_comb begin
        w_regs[0] = '0;
        for (int i = 1; i < REG_COUNT; i++) begin
            w_regs[i] = r_regs[i];
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    logic w_byp_vld;
    assign w_byp_vld = rf.write_enable && i_rst_n && (rf.write_register != REG_ZERO);
`endif

    mips_regfile_read_port u_port_a (
        .i_idx     (rf.register_a_index),
`ifdef REGFILE_WRITE_BYPASS_EN
        .i_byp_vld (w_byp_vld),
        .i_byp_idx (rf.write_register),
        .i_byp_dat (rf.write_data),
`endif
        .i_regs    (w_regs),
        .o_dat     (rf.register_a_data)
    );

    mips_regfile_read_port u_port_b (
        .i_idx     (rf.register_b_index),
`ifdef REGFILE_WRITE_BYPASS_EN
        .i_byp_vld (w_byp_vld),
        .i_byp_idx (rf.write_register),
        .i_byp_dat (rf.write_data),
`endif
        .i_regs    (w_regs),
        .o_dat     (rf.register_b_data)
    );

    always_comb begin
        rf.v0 = w_regs[REG_V0];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (w_byp_vld && (rf.write_register == REG_V0)) begin
            rf.v0 = rf.write_data;
        end
`endif
    end
endmodule

// File: tb/tb_mips_register_file.sv
// Directed bench for mips_register_file: expected values queued at drive time, popped at sample time.
module tb_mips_register_file;
    import mips_regfile_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    reg_word_t exp_q [$];

    mips_register_file_if rf ();

    mips_register_file dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .rf      (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input reg_word_t v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input reg_word_t obs);
        reg_word_t exp;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: observed %0d but scoreboard empty", tag, obs);
            return;
        end
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input reg_idx_t idx, input reg_word_t dat);
        rf.write_enable   = 1'b1;
        rf.write_register = idx;
        rf.write_data     = dat;
        tick();
        rf.write_enable   = 1'b0;
    endtask

    task automatic read_ab(input reg_idx_t a, input reg_idx_t b);
        rf.register_a_index = a;
        rf.register_b_index = b;
        #1;
    endtask

    initial begin
        reg_word_t pre_edge;
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        rf.write_enable     = 1'b0;
        rf.write_register   = '0;
        rf.write_data       = '0;
        rf.register_a_index = '0;
        rf.register_b_index = '0;
        tick();

        // reset state, while held and after release
        read_ab(5'd2, 5'd3);
        expect_val(0); check("rst_a2", rf.register_a_data);
        expect_val(0); check("rst_b3", rf.register_b_data);
        rst_n = 1'b1;
        tick();
        read_ab(5'd5, 5'd6);
        expect_val(0); check("rst_a5", rf.register_a_data);
        expect_val(0); check("rst_b6", rf.register_b_data);
        read_ab(5'd28, 5'd30);
        expect_val(0); check("rst_a28", rf.register_a_data);
        expect_val(0); check("rst_b30", rf.register_b_data);
        expect_val(0); check("rst_v0", rf.v0);

        // write then read; disabled write must not change anything
        write_reg(5'd28, 32'd10);
        read_ab(5'd28, 5'd0);
        expect_val(10); check("wr28_a", rf.register_a_data);
        rf.write_register = 5'd28;
        rf.write_data     = 32'd50;
        tick();
        expect_val(10); check("we0_hold28", rf.register_a_data);

        // overwrite on consecutive edges
        rf.register_b_index = 5'd28;
        write_reg(5'd28, 32'd50);
        expect_val(50); check("ovw1_b28", rf.register_b_data);
        write_reg(5'd28, 32'd25);
        expect_val(25); check("ovw2_b28", rf.register_b_data);

        // dual-port independence
        write_reg(5'd4, 32'd10);
        read_ab(5'd2, 5'd4);
        expect_val(0);  check("dual_a2", rf.register_a_data);
        expect_val(10); check("dual_b4", rf.register_b_data);

        // $v0 and $ra
        write_reg(5'd2, 32'd12);
        expect_val(12); check("v0_12", rf.v0);
        expect_val(12); check("a2_12", rf.register_a_data);
        write_reg(5'd31, 32'd10);
        read_ab(5'd31, 5'd31);
        expect_val(10); check("ra_a31", rf.register_a_data);
        expect_val(10); check("ra_b31", rf.register_b_data);

        // read during write: old value before the edge (new one with bypass), new after
        rf.write_enable     = 1'b1;
        rf.write_register   = 5'd5;
        rf.write_data       = 32'hDEAD_BEEF;
        rf.register_a_index = 5'd5;
        rf.register_b_index = 5'd28;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        pre_edge = 32'hDEAD_BEEF;
`else
        pre_edge = 32'd0;
`endif
        expect_val(pre_edge); check("rdw_pre_a5", rf.register_a_data);
        expect_val(25);       check("rdw_pre_b28", rf.register_b_data);
        tick();
        rf.write_enable = 1'b0;
        expect_val(32'hDEAD_BEEF); check("rdw_post_a5", rf.register_a_data);

        // v0 read during write
        rf.write_enable   = 1'b1;
        rf.write_register = 5'd2;
        rf.write_data     = 32'd99;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        pre_edge = 32'd99;
`else
        pre_edge = 32'd12;
`endif
        expect_val(pre_edge); check("v0_pre", rf.v0);
        tick();
        rf.write_enable = 1'b0;
        expect_val(99); check("v0_post", rf.v0);

        // $zero ignores writes, also in the same cycle
        rf.write_enable   = 1'b1;
        rf.write_register = 5'd0;
        rf.write_data     = 32'd20;
        read_ab(5'd0, 5'd0);
        expect_val(0); check("zero_pre_a", rf.register_a_data);
        tick();
        rf.write_enable = 1'b0;
        expect_val(0); check("zero_post_a", rf.register_a_data);
        expect_val(0); check("zero_post_b", rf.register_b_data);

        // async reset mid-cycle, no clock edge
        read_ab(5'd31, 5'd28);
        #1;
        rst_n = 1'b0;
        #1;
        expect_val(0); check("arst_a31", rf.register_a_data);
        expect_val(0); check("arst_b28", rf.register_b_data);
        expect_val(0); check("arst_v0", rf.v0);

        // writes suppressed (and not forwarded) while reset is low
        rf.write_enable     = 1'b1;
        rf.write_register   = 5'd3;
        rf.write_data       = 32'd9;
        rf.register_a_index = 5'd3;
        #1;
        expect_val(0); check("rst_nobyp_a3", rf.register_a_data);
        tick();
        rf.write_enable = 1'b0;
        rst_n = 1'b1;
        #1;
        expect_val(0); check("rst_nowr_a3", rf.register_a_data);
        expect_val(0); check("rst_rel_v0", rf.v0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
